wave_display: RTL and testbench

WAVE_DISPLAY -- requirements
Module: wave_display

---
 rtl/wave_display.sv | 169 ++++++++++++++++
 tb/tb_wave_display.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wave_display.sv
`default_nettype none
// ============================================================================
//  Module   : wave_display
//  Purpose  : Draws a captured waveform as a vertical-segment polyline in a
//             512x512 window (x 512..1023, y 0..511) of the video raster.
//             Each RAM sample spans two columns; a pixel is lit when its
//             row lies between the previous and current sample values.
//  Ports    : clk, reset (async, active-high)
//             x, y, valid        - raster position from the timing block
//             read_index         - buffer half last completed by capture
//             read_address       - {buffer bit, sample index} to sample RAM
//             read_value         - RAM data, one cycle after read_address
//             valid_pixel, r/g/b - pixel output, two cycles after x/y/valid
//             wave_display_idle  - high outside the window (buffer swap ok)
//  Revision : 1.0  initial release
// ============================================================================
module wave_display #(
    parameter logic [23:0] WAVE_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB   = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    output logic [8:0]  read_address,
    input  logic [7:0]  read_value,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    // Column and row LSBs are dropped: samples and rows are both doubled.
    logic unused_bits;
    assign unused_bits = &{1'b0, x[0], y[0]};

    // ------------------------------------------------------------------
    // Stage 0: window decode and RAM address
    // ------------------------------------------------------------------
    logic in_window;
    assign in_window = valid && (x[10:9] == 2'b01) && !y[9];

    logic buf_sel_q;
    assign read_address = {buf_sel_q, x[8:1]};

    // Idle goes high on any row below the window and only falls once a
    // visible in-window row starts; blanking cycles inside the frame hold it.
    logic idle_q, idle_d;
    always_comb begin
        idle_d = idle_q;
        if (y[9]) begin
            idle_d = 1'b1;
        end else if (valid) begin
            idle_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: registered position, aligned with the arriving read_value
    // ------------------------------------------------------------------
    logic       valid1_q, inwin1_q;
    logic [7:0] idx1_q, row1_q;
    logic [7:0] cur_sample_q, prev_sample_q, last_idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_sel_q <= 1'b0;
            idle_q    <= 1'b1;
            valid1_q  <= 1'b0;
            inwin1_q  <= 1'b0;
            idx1_q    <= 8'd0;
            row1_q    <= 8'd0;
        end else begin
            if (idle_q) begin
                buf_sel_q <= read_index;
            end
            idle_q   <= idle_d;
            valid1_q <= valid;
            inwin1_q <= in_window;
            idx1_q   <= x[8:1];
            row1_q   <= y[8:1];
        end
    end

    // Effective segment endpoints for the pixel now in stage 1. The current
    // endpoint is read_value itself; the previous endpoint is the sample of
    // the preceding index, collapsing to a single point at index 0.
    logic       line_start, new_index;
    logic [7:0] prev_eff;
    logic [7:0] seg_lo, seg_hi;
    logic       on_wave;

    always_comb begin
        line_start = (idx1_q == 8'd0);
        new_index  = (idx1_q != last_idx_q);
        prev_eff   = prev_sample_q;
        if (line_start) begin
            prev_eff = read_value;
        end else if (new_index) begin
            prev_eff = cur_sample_q;
        end
        if (prev_eff < read_value) begin
            seg_lo = prev_eff;
            seg_hi = read_value;
        end else begin
            seg_lo = read_value;
            seg_hi = prev_eff;
        end
        on_wave = (row1_q >= seg_lo) && (row1_q <= seg_hi);
    end

    logic [7:0] cur_sample_d, prev_sample_d, last_idx_d;
    always_comb begin
        cur_sample_d  = cur_sample_q;
        prev_sample_d = prev_sample_q;
        last_idx_d    = last_idx_q;
        if (inwin1_q) begin
            cur_sample_d  = read_value;
            prev_sample_d = prev_eff;
            last_idx_d    = idx1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_sample_q  <= 8'd0;
            prev_sample_q <= 8'd0;
            last_idx_q    <= 8'd0;
        end else begin
            cur_sample_q  <= cur_sample_d;
            prev_sample_q <= prev_sample_d;
            last_idx_q    <= last_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: registered pixel output, black whenever not valid
    // ------------------------------------------------------------------
    logic        pix_valid_d;
    logic [23:0] rgb_d;
    always_comb begin
        pix_valid_d = valid1_q && inwin1_q;
        rgb_d       = 24'd0;
        if (pix_valid_d) begin
            rgb_d = on_wave ? WAVE_RGB : BG_RGB;
        end
    end

    logic        valid_pixel_q;
    logic [23:0] rgb_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pixel_q <= 1'b0;
            rgb_q         <= 24'd0;
        end else begin
            valid_pixel_q <= pix_valid_d;
            rgb_q         <= rgb_d;
        end
    end

    assign valid_pixel       = valid_pixel_q;
    assign {r, g, b}         = rgb_q;
    assign wave_display_idle = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wave_display
//  Purpose  : Self-checking bench for wave_display. A behavioural model
//             tracks the polyline drawn on each line, the buffer selection
//             and the idle flag; DUT outputs are compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wave_display;

    localparam logic [23:0] C_WAVE = 24'hF0A055;
    localparam logic [23:0] C_BG   = 24'h102030;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [8:0]  read_address;
    logic [7:0]  read_value;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic        wave_display_idle;

    wave_display #(.WAVE_RGB(C_WAVE), .BG_RGB(C_BG)) dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
        .y                 (y),
        .valid             (valid),
        .read_index        (read_index),
        .read_address      (read_address),
        .read_value        (read_value),
        .valid_pixel       (valid_pixel),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .wave_display_idle (wave_display_idle)
    );

    always #5 clk = ~clk;

    // Synchronous-read sample RAM
    logic [7:0] mem [512];
    always @(posedge clk) read_value <= mem[read_address];

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        m_buf, m_idle;
    logic [7:0]  seg[$];        // last two distinct samples of the current line
    logic [7:0]  m_last;
    logic        p1_v, p2_v;
    logic [23:0] p1_rgb, p2_rgb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_buf  = 1'b0;
        m_idle = 1'b1;
        seg    = '{8'd0};
        m_last = 8'd0;
        p1_v = 1'b0; p2_v = 1'b0;
        p1_rgb = 24'd0; p2_rgb = 24'd0;
    endtask

    // One raster cycle: drive inputs, predict, clock, compare.
    task automatic cyc(input logic [10:0] xv, input logic [9:0] yv,
                       input logic vv, input logic ri);
        logic        inw, on, nidle, nbuf;
        logic [7:0]  idx, s, row, lo, hi;
        logic [23:0] nrgb;
        x = xv; y = yv; valid = vv; read_index = ri;
        #1;
        idx = xv[8:1];
        row = yv[8:1];
        check("read_address", {23'd0, read_address}, {23'd0, m_buf, idx});
        inw  = vv && (xv >= 11'd512) && (xv <= 11'd1023) && (yv < 10'd512);
        nrgb = 24'd0;
        if (inw) begin
            s = mem[{m_buf, idx}];
            if (idx == 8'd0) seg = '{s};
            else if (idx != m_last) seg.push_back(s);
            if (seg.size() > 2) void'(seg.pop_front());
            m_last = idx;
            lo = (seg[0] < seg[$]) ? seg[0] : seg[$];
            hi = (seg[0] < seg[$]) ? seg[$] : seg[0];
            on = (row >= lo) && (row <= hi);
            nrgb = on ? C_WAVE : C_BG;
        end
        nbuf  = m_idle ? ri : m_buf;
        nidle = (yv >= 10'd512) ? 1'b1 : (vv ? 1'b0 : m_idle);
        @(posedge clk);
        #1;
        p2_v = p1_v; p2_rgb = p1_rgb;
        p1_v = inw;  p1_rgb = nrgb;
        m_buf = nbuf; m_idle = nidle;
        check("valid_pixel", {31'd0, valid_pixel}, {31'd0, p2_v});
        check("rgb", {8'd0, r, g, b}, {8'd0, p2_rgb});
        check("idle", {31'd0, wave_display_idle}, {31'd0, m_idle});
    endtask

    task automatic line(input logic [9:0] yv, input int x0, input int x1, input logic ri);
        for (int i = x0; i <= x1; i++) cyc(11'(i), yv, 1'b1, ri);
    endtask

    initial begin
        reset = 1'b1; x = '0; y = '0; valid = 1'b0; read_index = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h40;
        model_reset();
        #1;
        check("reset_valid_pixel", {31'd0, valid_pixel}, 32'd0);
        check("reset_rgb", {8'd0, r, g, b}, 32'd0);
        check("reset_idle", {31'd0, wave_display_idle}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held_valid_pixel", {31'd0, valid_pixel}, 32'd0);
        reset = 1'b0;

        // Flat 0x40 waveform swept on row 64: every column lit
        cyc(11'd0, 10'd600, 1'b1, 1'b0);
        line(10'd128, 508, 1023, 1'b0);
        cyc(11'd0, 10'd128, 1'b0, 1'b0);
        cyc(11'd0, 10'd128, 1'b0, 1'b0);

        // Two-point segment 10 -> 20 on buffer 0
        mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd20;
        line(10'd30, 512, 517, 1'b0);  // row 15: in segment
        cyc(11'd0, 10'd30, 1'b0, 1'b0);
        line(10'd50, 512, 517, 1'b0);  // row 25: above segment
        cyc(11'd0, 10'd50, 1'b0, 1'b0);
        line(10'd20, 512, 517, 1'b0);  // row 10: single point at x=512
        cyc(11'd0, 10'd20, 1'b0, 1'b0);
        line(10'd22, 512, 517, 1'b0);  // row 11: not drawn at x=512
        cyc(11'd0, 10'd22, 1'b0, 1'b0);

        // Idle entry/exit
        cyc(11'd700, 10'd600, 1'b1, 1'b0);
        cyc(11'd600, 10'd0, 1'b1, 1'b0);

        // Buffer swap only while idle
        for (int i = 256; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
        cyc(11'd0, 10'd600, 1'b1, 1'b1);
        line(10'd100, 512, 600, 1'b1);
        line(10'd100, 601, 700, 1'b0);
        line(10'd102, 512, 700, 1'b0);
        cyc(11'd0, 10'd512, 1'b1, 1'b0);
        line(10'd0, 512, 540, 1'b0);

        // Randomised lines, RAM contents, valid gaps and read_index
        for (int ln = 0; ln < 8; ln++) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) cyc(11'd0, 10'd700, 1'b1, 1'($urandom_range(0, 1)));
            begin
                logic [9:0] yr;
                yr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(512, 1023))
                                                 : 10'($urandom_range(0, 511));
                for (int i = 496; i <= 1040; i++)
                    cyc(11'(i), yr, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
            end
        end

        // Asynchronous reset in mid-line, then recovery
        cyc(11'd0, 10'd600, 1'b1, 1'b0);
        line(10'd200, 512, 700, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_valid_pixel", {31'd0, valid_pixel}, 32'd0);
        check("async_reset_rgb", {8'd0, r, g, b}, 32'd0);
        check("async_reset_idle", {31'd0, wave_display_idle}, 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        line(10'd200, 512, 530, 1'b0);
        cyc(11'd0, 10'd200, 1'b0, 1'b0);
        cyc(11'd0, 10'd200, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
